// File: rtl/snake_dir_ctrl.sv
// Snake heading front-end: synchronizes and debounces five active-low buttons,
// turns presses into a reversal-proof one-hot heading, and handles pause.
module snake_dir_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic iVGA_CLK,
  input  logic iRST_n,
  input  logic key_up_n,
  input  logic key_down_n,
  input  logic key_left_n,
  input  logic key_right_n,
  input  logic key_pause_n,
  output logic move_up,
  output logic move_down,
  output logic move_left,
  output logic move_right,
  output logic paused
);

  localparam int NK = 5;
  // Flip on the (DEBOUNCE_CYCLES-1)th mismatched edge so stable moves at k+1+DEBOUNCE_CYCLES.
  localparam logic [CNT_W-1:0] CNT_FLIP = CNT_W'(DEBOUNCE_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_UP    = 3'd1,
    S_DOWN  = 3'd2,
    S_LEFT  = 3'd3,
    S_RIGHT = 3'd4
  } state_t;

  // Key bit order everywhere: [0]=up [1]=down [2]=left [3]=right [4]=pause.
  logic [NK-1:0]    w_raw;
  logic [NK-1:0]    r_sync1;
  logic [NK-1:0]    r_sync2;
  logic [NK-1:0]    r_stable;
  logic [NK-1:0]    r_stable_d;
  logic [CNT_W-1:0] r_cnt [NK];
  logic [NK-1:0]    w_press;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_paused;
  logic             w_paused_nxt;
  logic [3:0]       r_move;
  logic [3:0]       w_move_nxt;
  logic [3:0]       w_legal;
  logic [3:0]       w_dir_ev;

  assign w_raw   = ~{key_pause_n, key_right_n, key_left_n, key_down_n, key_up_n};
  assign w_press = r_stable & ~r_stable_d;

  // Two-flop synchronizer on the inverted (active-high) keys.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_sync1 <= {NK{1'b0}};
      r_sync2 <= {NK{1'b0}};
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Per-key debounce counter; any single matching cycle restarts the count.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_stable   <= {NK{1'b0}};
      r_stable_d <= {NK{1'b0}};
      for (int i = 0; i < NK; i++) r_cnt[i] <= '0;
    end else begin
      r_stable_d <= r_stable;
      for (int i = 0; i < NK; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_FLIP) begin
          r_stable[i] <= r_sync2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // Heading state, pause flag and output registers.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_state  <= S_IDLE;
      r_paused <= 1'b0;
      r_move   <= 4'b0000;
    end else begin
      r_state  <= w_state_nxt;
      r_paused <= w_paused_nxt;
      r_move   <= w_move_nxt;
    end
  end

  // Next heading: drop illegal events, then up > down > left > right.
  always_comb begin
    w_legal      = 4'b0000;
    w_state_nxt  = r_state;
    w_move_nxt   = 4'b0000;
    w_paused_nxt = r_paused ^ w_press[4];

    case (r_state)
      S_IDLE:          w_legal = 4'b1011;
      S_UP, S_DOWN:    w_legal = 4'b1100;
      S_LEFT, S_RIGHT: w_legal = 4'b0011;
      default:         w_legal = 4'b0000;
    endcase

    w_dir_ev = w_press[3:0] & w_legal & {4{~r_paused}};

    if (w_dir_ev[0]) begin
      w_state_nxt = S_UP;
    end else if (w_dir_ev[1]) begin
      w_state_nxt = S_DOWN;
    end else if (w_dir_ev[2]) begin
      w_state_nxt = S_LEFT;
    end else if (w_dir_ev[3]) begin
      w_state_nxt = S_RIGHT;
    end else begin
      w_state_nxt = r_state;
    end

    if (w_paused_nxt) begin
      w_move_nxt = 4'b0000;
    end else begin
      w_move_nxt = {w_state_nxt == S_RIGHT, w_state_nxt == S_LEFT,
                    w_state_nxt == S_DOWN,  w_state_nxt == S_UP};
    end
  end

  assign move_up    = r_move[0];
  assign move_down  = r_move[1];
  assign move_left  = r_move[2];
  assign move_right = r_move[3];
  assign paused     = r_paused;

endmodule
